// File: rtl/oai32_bist_ctrl_if.sv
// Handshake and result bundle between the oai32 BIST sequencer and its user.
// The user drives start/abort and returns the cell's ZN; the sequencer drives the cell pins and the results.
interface oai32_bist_ctrl_if #(
   parameter int ERR_W = 6
);
   logic             start;
   logic             abort;
   logic             zn_in;
   logic             a1;
   logic             a2;
   logic             a3;
   logic             b1;
   logic             b2;
   logic             busy;
   logic             done;
   logic             pass;
   logic [ERR_W-1:0] err_cnt;
   logic             fail_vld;
   logic [4:0]       fail_vec;

   modport master (
      output start, abort, zn_in,
      input  a1, a2, a3, b1, b2, busy, done, pass, err_cnt, fail_vld, fail_vec
   );

   modport slave (
      input  start, abort, zn_in,
      output a1, a2, a3, b1, b2, busy, done, pass, err_cnt, fail_vld, fail_vec
   );
endinterface

// File: rtl/oai32_bist_ctrl.sv
// Exhaustive 32-vector self-test sequencer for one oai32 cell: ZN = !((A1|A2|A3) & (B1|B2)).
// Reports pass/fail, a saturating mismatch count and the first failing vector.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | waiting for start, cell pins held at vector 0
// ST_DRIVE | current vector applied, settle down-counter running
// ST_CHECK | one cycle, ZN compared against golden at the closing edge
// ST_DONE  | all 32 vectors checked, results held until start or abort
module oai32_bist_ctrl #(
   parameter int SETTLE_CYC = 2,
   parameter int ERR_W      = 6
) (
   input  logic               clk,
   input  logic               rst,
   oai32_bist_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DRIVE,
      ST_CHECK,
      ST_DONE
   } state_t;

   localparam int CNT_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

   state_t           state;
   logic [4:0]       vec;
   logic [CNT_W-1:0] settle_cnt;
   logic [ERR_W-1:0] err_cnt;
   logic             fail_vld;
   logic [4:0]       fail_vec;
   logic             busy;
   logic             done;
   logic             pass;

   logic             golden_zn;
   logic             mismatch;
   logic             err_sat;

   // vec bit order is {B2,B1,A3,A2,A1}
   assign golden_zn = ~((vec[0] | vec[1] | vec[2]) & (vec[3] | vec[4]));
   assign mismatch  = (bus.zn_in != golden_zn);
   assign err_sat   = &err_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= ST_IDLE;
         vec        <= '0;
         settle_cnt <= '0;
         err_cnt    <= '0;
         fail_vld   <= 1'b0;
         fail_vec   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
      end else if (bus.abort) begin
         // results of the interrupted run stay visible for debug
         state      <= ST_IDLE;
         vec        <= '0;
         settle_cnt <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (bus.start) begin
                  state      <= ST_DRIVE;
                  vec        <= '0;
                  settle_cnt <= SETTLE_LOAD;
                  err_cnt    <= '0;
                  fail_vld   <= 1'b0;
                  fail_vec   <= '0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
               end
            end
            ST_DRIVE: begin
               if (settle_cnt == '0) begin
                  state <= ST_CHECK;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            ST_CHECK: begin
               if (mismatch) begin
                  if (!err_sat) begin
                     err_cnt <= err_cnt + 1'b1;
                  end
                  if (!fail_vld) begin
                     fail_vld <= 1'b1;
                     fail_vec <= vec;
                  end
               end
               if (vec == 5'd31) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  // a nonzero count can never return to zero, so this covers saturation too
                  pass  <= (err_cnt == '0) && !mismatch;
               end else begin
                  state      <= ST_DRIVE;
                  vec        <= vec + 5'd1;
                  settle_cnt <= SETTLE_LOAD;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.a1       = vec[0];
   assign bus.a2       = vec[1];
   assign bus.a3       = vec[2];
   assign bus.b1       = vec[3];
   assign bus.b2       = vec[4];
   assign bus.busy     = busy;
   assign bus.done     = done;
   assign bus.pass     = pass;
   assign bus.err_cnt  = err_cnt;
   assign bus.fail_vld = fail_vld;
   assign bus.fail_vec = fail_vec;

endmodule
